// File: rtl/lab71_soc_ctrl_out.sv
// rtl/lab71_soc_ctrl_out.sv - Avalon-MM output port with set/clear and timed pulse generator
//
// Purpose: memory-mapped output register. DATA can be written, bit-set or
// bit-cleared, and a pulse engine forces selected bits high for a
// programmable number of cycles.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   address     word address (0 DATA, 1 PULSE_LEN, 2 PULSE, 4 OUTSET, 5 OUTCLEAR)
//   chipselect  slave select; reads and writes are ignored when low
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data
//   readdata    registered read data, latency 1
//   out_port    registered output pins = DATA | active_mask
module lab71_soc_ctrl_out #(
    parameter int unsigned           WIDTH       = 8,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd1;
    localparam logic [2:0] ADDR_PULSE     = 3'd2;
    localparam logic [2:0] ADDR_OUTSET    = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [15:0]      pulse_len_q, pulse_len_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] out_q;

    logic             wr;
    logic [WIDTH-1:0] wdata;
    logic [31:0]      data_ext;
    logic [31:0]      mask_ext;
    logic             unused_bits;

    assign wr       = chipselect & ~write_n;
    assign wdata    = writedata[WIDTH-1:0];
    assign data_ext = 32'(data_q);
    assign mask_ext = 32'(mask_q);
    // Only the low 16 mask bits are visible in the PULSE status word.
    assign unused_bits = ^{writedata[31:16], mask_ext[31:16]};

    // Register updates and pulse FSM next-state.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        mask_d      = mask_q;
        pulse_len_d = pulse_len_q;
        cnt_d       = cnt_q;

        if (wr) begin
            case (address)
                ADDR_DATA:      data_d      = wdata;
                ADDR_PULSE_LEN: pulse_len_d = writedata[15:0];
                ADDR_OUTSET:    data_d      = data_q | wdata;
                ADDR_OUTCLEAR:  data_d      = data_q & ~wdata;
                default:        ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (wr && address == ADDR_PULSE && wdata != '0) begin
                    mask_d  = wdata;
                    // A zero length still produces a one-cycle pulse.
                    cnt_d   = (pulse_len_q == 16'd0) ? 16'd1 : pulse_len_q;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                // PULSE writes are ignored here: no restart, no extension.
                if (cnt_q == 16'd1) begin
                    mask_d  = '0;
                    cnt_d   = 16'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                mask_d  = '0;
                cnt_d   = 16'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read mux works on current state, so a same-cycle write reads the old value.
    always_comb begin
        readdata_d = 32'd0;
        if (chipselect) begin
            case (address)
                ADDR_DATA:      readdata_d = data_ext;
                ADDR_PULSE_LEN: readdata_d = {16'd0, pulse_len_q};
                ADDR_PULSE:     readdata_d = {(state_q == ST_ACTIVE), 15'd0, mask_ext[15:0]};
                default:        readdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            data_q      <= RESET_VALUE;
            mask_q      <= '0;
            pulse_len_q <= 16'd1;
            cnt_q       <= 16'd0;
            readdata_q  <= 32'd0;
            out_q       <= RESET_VALUE;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            pulse_len_q <= pulse_len_d;
            cnt_q       <= cnt_d;
            readdata_q  <= readdata_d;
            // Built from next-state values so the pins track DATA | mask exactly.
            out_q       <= data_d | mask_d;
        end
    end

    assign readdata = readdata_q;
    assign out_port = out_q;

endmodule

// File: tb/tb_lab71_soc_ctrl_out.sv
// tb/tb_lab71_soc_ctrl_out.sv - directed self-checking bench for lab71_soc_ctrl_out
module tb_lab71_soc_ctrl_out;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int n_cmp = 0;
    int n_err = 0;

    lab71_soc_ctrl_out #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [2:0] a);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        chipselect = 1'b0;
    endtask

    initial begin
        // Reset with a coincident DATA write that must be overridden.
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = 32'hFF;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_out", 32'(out_port), 32'h00);
        check("rst_rd", readdata, 32'h0);
        bus_rd(3'd0);
        check("rst_data", readdata, 32'h0);
        bus_rd(3'd1);
        check("rst_plen", readdata, 32'h1);

        // DATA / OUTSET / OUTCLEAR
        bus_wr(3'd0, 32'hA5);
        check("data_wr", 32'(out_port), 32'hA5);
        bus_wr(3'd4, 32'h0A);
        check("outset", 32'(out_port), 32'hAF);
        bus_wr(3'd5, 32'h81);
        check("outclr", 32'(out_port), 32'h2E);
        bus_rd(3'd0);
        check("rd_data", readdata, 32'h2E);

        // Unmapped address and deselected write are ignored.
        bus_wr(3'd3, 32'hFF);
        bus_rd(3'd3);
        check("rd_unmapped", readdata, 32'h0);
        address    = 3'd0;
        writedata  = 32'h11;
        chipselect = 1'b0;
        write_n    = 1'b0;
        tick();
        write_n = 1'b1;
        check("cs_low_wr", 32'(out_port), 32'h2E);

        // Same-cycle write and read returns the pre-write value.
        address    = 3'd0;
        writedata  = 32'h00;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        check("wr_rd_old", readdata, 32'h2E);
        check("wr_rd_new", 32'(out_port), 32'h00);

        // 3-cycle pulse on bit 0.
        bus_wr(3'd1, 32'd3);
        bus_rd(3'd1);
        check("rd_plen3", readdata, 32'd3);
        bus_wr(3'd2, 32'h01);
        check("p3_c1", 32'(out_port), 32'h01);
        bus_rd(3'd2);
        check("p3_status", readdata, 32'h8000_0001);
        check("p3_c2", 32'(out_port), 32'h01);
        tick();
        check("p3_c3", 32'(out_port), 32'h01);
        tick();
        check("p3_end", 32'(out_port), 32'h00);
        bus_rd(3'd2);
        check("p3_idle", readdata, 32'h0);

        // PULSE_LEN=0 gives a single-cycle pulse.
        bus_wr(3'd1, 32'd0);
        bus_wr(3'd2, 32'h04);
        check("p0_c1", 32'(out_port), 32'h04);
        tick();
        check("p0_end", 32'(out_port), 32'h00);

        // Zero mask does not start a pulse.
        bus_wr(3'd2, 32'h00);
        bus_rd(3'd2);
        check("pz_idle", readdata, 32'h0);

        // 10-cycle pulse; a second PULSE write mid-pulse is ignored.
        bus_wr(3'd1, 32'd10);
        bus_wr(3'd2, 32'h01);
        check("p10_c1", 32'(out_port), 32'h01);
        for (int k = 2; k <= 10; k++) begin
            if (k == 4) bus_wr(3'd2, 32'h02);
            else        tick();
            check($sformatf("p10_c%0d", k), 32'(out_port), 32'h01);
        end
        tick();
        check("p10_end", 32'(out_port), 32'h00);

        // OUTCLEAR during a pulse leaves the forced bit high; reset aborts it.
        bus_wr(3'd2, 32'h01);
        check("pr_c1", 32'(out_port), 32'h01);
        bus_wr(3'd5, 32'h01);
        check("pr_clr", 32'(out_port), 32'h01);
        tick();
        tick();
        check("pr_c4", 32'(out_port), 32'h01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("pr_rst_out", 32'(out_port), 32'h00);
        bus_rd(3'd2);
        check("pr_rst_busy", readdata, 32'h0);
        tick();
        check("pr_rst_hold", 32'(out_port), 32'h00);
        bus_rd(3'd1);
        check("pr_rst_plen", readdata, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
